// File: rtl/ring_rot_pkg.sv
// Shared definitions for the register-ring rotator family.
// Holds the FSM state encoding, default geometry and the lane reset-value function.
package ring_rot_pkg;

    localparam int unsigned DEF_WIDTH  = 2;
    localparam int unsigned DEF_DEPTH  = 3;
    localparam int unsigned DEF_STEP_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ROT  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Reset value of lane idx: (idx+1) mod 2^width.
    function automatic int unsigned lane_rst_val(input int unsigned idx, input int unsigned width);
        return 32'((64'(idx) + 64'd1) % (64'd1 << width));
    endfunction

endpackage

// File: rtl/ring_unrotate_if.sv
// Input word/step-count handshake and restored-word output handshake.
// master: producer/consumer side (testbench or surrounding logic).
// slave : the ring_unrotate block.
interface ring_unrotate_if #(
    parameter int unsigned WIDTH  = 2,
    parameter int unsigned DEPTH  = 3,
    parameter int unsigned STEP_W = 4
);
    logic                     in_valid;
    logic                     in_ready;
    logic [WIDTH*DEPTH-1:0]   in_data;
    logic [STEP_W-1:0]        in_steps;
    logic                     out_valid;
    logic                     out_ready;
    logic [WIDTH*DEPTH-1:0]   out_data;
    logic                     out_err;

    modport master (
        output in_valid, in_data, in_steps, out_ready,
        input  in_ready, out_valid, out_data, out_err
    );

    modport slave (
        input  in_valid, in_data, in_steps, out_ready,
        output in_ready, out_valid, out_data, out_err
    );
endinterface

// File: rtl/ring_lane_bank.sv
// DEPTH x WIDTH lane registers with parallel load and a one-step backward rotation.
// Ports: clk, rst (sync, active-low), load + load_data, step_back, lanes (packed, lane0 in LSBs).
module ring_lane_bank
    import ring_rot_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned DEPTH = DEF_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load,
    input  logic                   step_back,
    input  logic [WIDTH*DEPTH-1:0] load_data,
    output logic [WIDTH*DEPTH-1:0] lanes
);

    logic [WIDTH-1:0] lane_q [DEPTH];

    for (genvar g = 0; g < DEPTH; g++) begin : g_lane
        localparam int unsigned    NXT   = (g + 1) % DEPTH;
        localparam logic [WIDTH-1:0] RST_V = WIDTH'(lane_rst_val(g, WIDTH));

        // Backward step: each lane takes its upper neighbour, wrapping at the top.
        always_ff @(posedge clk) begin
            if (!rst) begin
                lane_q[g] <= RST_V;
            end else if (load) begin
                lane_q[g] <= load_data[g*WIDTH +: WIDTH];
            end else if (step_back) begin
                lane_q[g] <= lane_q[NXT];
            end
        end

        assign lanes[g*WIDTH +: WIDTH] = lane_q[g];
    end

endmodule

// File: rtl/ring_unrotate.sv
// Undoes k forward ring rotations by stepping the lanes backwards once per clock,
// then offers the restored word on a valid/ready output.
// Ports: clk, rst (sync, active-low), bus (ring_unrotate_if.slave: in_* accept side,
//        out_* restored-word side, out_err step-count error).
// Optional feature: RING_UNROT_STRICT_EN flags in_steps >= DEPTH as an error and
// passes the word through unrotated; otherwise steps are reduced modulo DEPTH.
module ring_unrotate
    import ring_rot_pkg::*;
#(
    parameter int unsigned WIDTH  = DEF_WIDTH,
    parameter int unsigned DEPTH  = DEF_DEPTH,
    parameter int unsigned STEP_W = DEF_STEP_W
) (
    input  logic          clk,
    input  logic          rst,
    ring_unrotate_if.slave bus
);

    localparam int unsigned REM_W = $clog2(DEPTH);

    state_t             state_q;
    state_t             state_nxt;
    logic [REM_W-1:0]   rem_q;
    logic [REM_W-1:0]   k;
    logic               step_err;
    logic               in_ready_c;
    logic               out_valid_c;
    logic               load;
    logic               step_back;
    logic               out_hs;
    logic [WIDTH*DEPTH-1:0] lanes;

    // Step count reduced modulo the ring size.
    assign k = REM_W'(bus.in_steps % STEP_W'(DEPTH));

`ifdef RING_UNROT_STRICT_EN
    logic err_q;

    assign step_err = (32'(bus.in_steps) >= DEPTH);

    // Error flag lives for one output word; cleared on its handshake.
    always_ff @(posedge clk) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else if (load) begin
            err_q <= step_err;
        end else if (out_hs) begin
            err_q <= 1'b0;
        end
    end

    assign bus.out_err = err_q;
`else
    assign step_err    = 1'b0;
    assign bus.out_err = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    state_nxt = ((k == '0) || step_err) ? DONE : ROT;
                end
            end
            ROT: begin
                if (rem_q == REM_W'(1)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode; in_ready is masked by reset so nothing is offered while held.
    always_comb begin
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        step_back   = 1'b0;
        case (state_q)
            IDLE:    in_ready_c  = rst;
            ROT:     step_back   = 1'b1;
            DONE:    out_valid_c = 1'b1;
            default: ;
        endcase
    end

    assign load   = bus.in_valid && in_ready_c;
    assign out_hs = out_valid_c && bus.out_ready;

    // Remaining backward steps; an erroneous word is never rotated.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rem_q <= '0;
        end else if (load) begin
            rem_q <= step_err ? '0 : k;
        end else if (step_back) begin
            rem_q <= rem_q - REM_W'(1);
        end
    end

    ring_lane_bank #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_bank (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .step_back (step_back),
        .load_data (bus.in_data),
        .lanes     (lanes)
    );

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.out_data  = lanes;

endmodule

// File: tb/tb_ring_unrotate.sv
// Directed self-checking bench for ring_unrotate (WIDTH=2, DEPTH=3, STEP_W=4).
module tb_ring_unrotate;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    ring_unrotate_if #(.WIDTH(2), .DEPTH(3), .STEP_W(4)) bus ();

    ring_unrotate #(.WIDTH(2), .DEPTH(3), .STEP_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one word from IDLE, measure latency, check output, complete the handshake.
    task automatic run(input string tag, input logic [5:0] d, input logic [3:0] s,
                       input logic [5:0] exp_d, input logic exp_e, input int exp_lat);
        int lat;
        chk({tag, "_in_ready_idle"}, 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_steps = s;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_data  = 6'h15;
        bus.in_steps = 4'hF;
        lat = 1;
        while (!bus.out_valid && lat < 12) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_data"}, 32'(bus.out_data), 32'(exp_d));
        chk({tag, "_err"}, 32'(bus.out_err), 32'(exp_e));
        chk({tag, "_in_ready_done"}, 32'(bus.in_ready), 32'd0);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk({tag, "_valid_after_hs"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_err_after_hs"}, 32'(bus.out_err), 32'd0);
    endtask

    initial begin
        logic [5:0] held;
        vectors      = 0;
        miscompares  = 0;
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_steps = '0;
        bus.out_ready = 1'b0;

        // Reset state.
        @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_data", 32'(bus.out_data), 32'h39);
        chk("rst_out_err", 32'(bus.out_err), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

        // out_ready while idle does nothing.
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk("idle_ready_valid", 32'(bus.out_valid), 32'd0);
        chk("idle_ready_in_ready", 32'(bus.in_ready), 32'd1);

        // Main function.
        run("k1", 6'h27, 4'd1, 6'h39, 1'b0, 2);
        run("k2", 6'h1E, 4'd2, 6'h39, 1'b0, 3);
        run("k0", 6'h27, 4'd0, 6'h27, 1'b0, 1);
`ifdef RING_UNROT_STRICT_EN
        run("s4", 6'h27, 4'd4, 6'h27, 1'b1, 1);
        run("s5", 6'h1E, 4'd5, 6'h1E, 1'b1, 1);
        run("s3", 6'h27, 4'd3, 6'h27, 1'b1, 1);
        run("s15", 6'h2D, 4'd15, 6'h2D, 1'b1, 1);
`else
        run("s4", 6'h27, 4'd4, 6'h39, 1'b0, 2);
        run("s5", 6'h1E, 4'd5, 6'h39, 1'b0, 3);
        run("s3", 6'h27, 4'd3, 6'h27, 1'b0, 1);
        run("s15", 6'h2D, 4'd15, 6'h2D, 1'b0, 1);
`endif
        // Lanes (1,3,2) = 0x2D, one step back -> (3,2,1) = 0x1B.
        run("k1b", 6'h2D, 4'd1, 6'h1B, 1'b0, 2);

        // Backpressure: hold out_ready low 5 cycles in DONE with noise on the input side.
        bus.in_valid = 1'b1;
        bus.in_data  = 6'h27;
        bus.in_steps = 4'd0;
        @(posedge clk);
        @(negedge clk);
        held = 6'h27;
        bus.in_data  = 6'h00;
        bus.in_steps = 4'd2;
        for (int c = 0; c < 5; c++) begin
            chk("stall_valid", 32'(bus.out_valid), 32'd1);
            chk("stall_data", 32'(bus.out_data), 32'(held));
            chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
            @(negedge clk);
        end
        // in_valid still high across the handshake edge: must not be accepted that edge.
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        chk("stall_clear_valid", 32'(bus.out_valid), 32'd0);
        chk("stall_clear_in_ready", 32'(bus.in_ready), 32'd1);
        chk("stall_clear_data", 32'(bus.out_data), 32'(held));
        @(negedge clk);
        chk("idle_hold_valid", 32'(bus.out_valid), 32'd0);

        // Reset during ROT discards the word.
        bus.in_valid = 1'b1;
        bus.in_data  = 6'h1E;
        bus.in_steps = 4'd2;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("midrot_valid", 32'(bus.out_valid), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("midrot_rst_valid", 32'(bus.out_valid), 32'd0);
        chk("midrot_rst_data", 32'(bus.out_data), 32'h39);
        chk("midrot_rst_in_ready", 32'(bus.in_ready), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("midrot_after_in_ready", 32'(bus.in_ready), 32'd1);
        chk("midrot_after_valid", 32'(bus.out_valid), 32'd0);

        // Normal operation resumes after reset.
        run("post", 6'h1E, 4'd2, 6'h39, 1'b0, 3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ring_unrotate.md
# ring_unrotate

Inverse of the team's forward register-ring rotator: each forward step performs lane[i] <= lane[(i-1) mod DEPTH], and this block undoes it. It accepts a packed word of DEPTH lanes together with the number of forward steps that were applied. It then rotates backwards one step per clock and presents the restored word on a valid/ready output. It sits on the consumer side of the rotator, restoring lane order before downstream logic.

## Interface
- WIDTH, 2: bits per lane.
- DEPTH, 3: number of lanes; must be ≥ 2.
- STEP_W, 4: width of the step-count input.
- clk  input  1  rising-edge clock.
- rst  input  1  reset, synchronous, active-low.
- in_valid  input  1  upstream word and step count valid.
- in_ready  output  1  block can accept; high only in IDLE with rst high.
- in_data  input  WIDTH*DEPTH  packed lanes, lane0 in LSBs.
- in_steps  input  STEP_W  forward steps applied upstream.
- out_valid  output  1  restored word available.
- out_ready  input  1  downstream accepts.
- out_data  output  WIDTH*DEPTH  restored lanes, lane0 in LSBs.
- out_err  output  1  step-count error flag; see Configuration.

## Operation
- FSM states:
  - IDLE: in_ready=1.
  - ROT: one backward step per cycle.
  - DONE: out_valid=1.
- Accept: on in_valid&&in_ready at a clock edge:
  - lanes <= in_data.
  - rem <= k, where k = in_steps mod DEPTH.
  - Next state is DONE if k==0, else ROT.
- ROT, each edge:
  - lane[i] <= lane[(i+1) mod DEPTH] for all i, simultaneously.
  - rem decrements.
  - When rem==1, go to DONE.
- DONE:
  - out_data and out_err are held stable until out_valid&&out_ready.
  - On that handshake, go to IDLE.
- No same-cycle DONE→accept: a new word can be accepted no earlier than the cycle after the output handshake.
- in_data and in_steps are ignored outside the accept edge.

## Timing
- Reset (rst low at an edge):
  - state=IDLE, rem=0.
  - lane[i] = (i+1) mod 2^WIDTH; with the defaults, lanes are (1,2,3).
  - out_valid=0, out_err=0.
  - in_ready=0 while rst is low.
- out_data continuously reflects the lane registers; it is only meaningful while out_valid=1.
- Latency: with accept at edge T, out_valid is high in the cycle after edge T+k, giving k+1 cycles from accept.
- Throughput: one word per k+2 cycles when out_ready is held high.
- Reset mid-ROT or mid-DONE: the word is discarded, no output handshake occurs, and registers take their reset values.
- out_ready high while out_valid is low has no effect.
- in_valid is not required to be held stable while in_ready is low.

## Configuration
- RING_UNROT_STRICT_EN defined:
  - in_steps ≥ DEPTH is an error.
  - The word is loaded unrotated, the FSM goes straight to DONE, and out_err=1 for that output.
  - out_err is cleared on the output handshake.
- RING_UNROT_STRICT_EN undefined:
  - Steps are reduced modulo DEPTH.
  - out_err is tied to 0.

## Structure
- Package ring_rot_pkg holds:
  - the FSM state enum (IDLE, ROT, DONE);
  - the lane-reset-value function (i+1 mod 2^WIDTH);
  - shared default parameters (WIDTH, DEPTH), also used by the forward rotator.
- One sub-module, ring_lane_bank:
  - DEPTH×WIDTH registers with synchronous active-low reset to the package values;
  - load and step_back controls;
  - packed output.
- The top level contains the FSM, the rem counter, the modulo reduction and the error logic.

## Test plan
- Defaults, in_data=0x27 (lanes 3,1,2), in_steps=1 → out_data=0x39 (lanes 1,2,3); out_valid 2 cycles after accept.
- in_data=0x1E (lanes 2,3,1), in_steps=2 → out_data=0x39; latency 3 cycles.
- in_steps=0, in_data=0x27 → out_data=0x27; latency 1 cycle.
- in_steps=4, in_data=0x27:
  - without RING_UNROT_STRICT_EN → 0x39, out_err=0;
  - with it → 0x27, out_err=1, latency 1 cycle.
- out_ready held low for 5 cycles in DONE → out_data and out_valid stable, in_ready=0; clears one cycle after out_ready rises.
- rst low for one edge during ROT → next cycle out_valid=0, out_data=0x39 (reset lanes 1,2,3); in_ready=1 in the first cycle after rst returns high.
